// File: rtl/mem_requester_if.sv
// Core request/response and memory bus signals of mem_requester.
// master = requester side, slave = core plus responder side.
interface mem_requester_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_trig;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_adbus;
  logic              mem_busy;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata,
    input  mem_busy, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_trig, mem_rw, mem_adbus
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata,
    output mem_busy, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_trig, mem_rw, mem_adbus
  );
endinterface

// File: rtl/mem_requester.sv
// Bus master for the 8-bit multiplexed single-port memory bus.
// Define MEM_REQ_TIMEOUT_EN to enable the wait-cycle abort.
module mem_requester #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic            CLK,
  input logic            RST,
  mem_requester_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, ADDR, WAIT, RESP
  } state_t;

  state_t state, state_nxt;

  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              trig_q;
  logic              rw_bus_q;
  logic [ADDR_W-1:0] adbus_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              done;
  logic              tmo;

  assign accept = (state == IDLE) && bus.req_valid;
  assign done   = (state == WAIT) && bus.mem_busy;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       err_q;
  logic       in_wait;

  assign in_wait = (state == ADDR) || (state == WAIT);
  assign cnt_inc = cnt + 8'd1;
  // normal completion wins over a coincident timeout
  assign tmo = in_wait && (cnt_inc == TMO) && !done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept)
        cnt <= '0;
      else if (in_wait)
        cnt <= cnt_inc;
      if (accept || state == RESP)
        err_q <= 1'b0;
      else if (tmo)
        err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign tmo         = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.req_valid) state_nxt = ADDR;
      ADDR: begin
        if (tmo)
          state_nxt = RESP;
        else if (!bus.mem_busy)
          state_nxt = WAIT;
      end
      WAIT: if (done || tmo) state_nxt = RESP;
      RESP: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      trig_q   <= 1'b0;
      rw_bus_q <= 1'b0;
      adbus_q  <= '0;
      rdata_q  <= '0;
    end else if (accept) begin
      rw_q     <= bus.req_rw;
      wdata_q  <= bus.req_wdata;
      trig_q   <= 1'b1;
      rw_bus_q <= bus.req_rw;
      adbus_q  <= bus.req_addr;
    end else if (done || tmo) begin
      // bus is released on the edge that enters RESP
      trig_q   <= 1'b0;
      rw_bus_q <= 1'b0;
      adbus_q  <= '0;
      rdata_q  <= (done && rw_q) ? bus.mem_rdata : '0;
    end else if (state == ADDR && !bus.mem_busy && !rw_q) begin
      adbus_q  <= wdata_q;
    end
  end

  assign bus.req_ready = RST && (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_trig  = trig_q;
  assign bus.mem_rw    = rw_bus_q;
  assign bus.mem_adbus = adbus_q;

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a one-cycle memory responder model.
// Build with MEM_REQ_TIMEOUT_EN to add the timeout scenario.
module tb_mem_requester;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic force_busy = 1'b0;
  logic hang = 1'b0;

  int vecs = 0;
  int errs = 0;
  int writes = 0;

  logic       busy_m;
  logic       rw_m;
  logic [7:0] a_m;
  logic [7:0] mem [256];

  mem_requester_if bus ();

  mem_requester #(
    .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  assign bus.mem_busy  = busy_m | force_busy;
  assign bus.mem_rdata = busy_m ? mem[a_m] : 8'h00;

  // responder: accepts trig when idle, busy for exactly one cycle
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_m <= 1'b0;
      rw_m   <= 1'b0;
      a_m    <= 8'h00;
    end else if (busy_m) begin
      if (!rw_m) begin
        mem[a_m] <= bus.mem_adbus;
        writes   <= writes + 1;
      end
      busy_m <= 1'b0;
    end else if (bus.mem_trig && !force_busy && !hang) begin
      busy_m <= 1'b1;
      rw_m   <= bus.mem_rw;
      a_m    <= bus.mem_adbus;
    end
  end

  task automatic start_req(input logic rw, input logic [7:0] addr,
                           input logic [7:0] wd);
    @(posedge CLK);
    @(negedge CLK);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  task automatic do_req(input logic rw, input logic [7:0] addr,
                        input logic [7:0] wd, output int n,
                        output logic [7:0] rd, output logic err);
    n = -1;
    rd = 8'h00;
    err = 1'b0;
    start_req(rw, addr, wd);
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK);
      #1;
      bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin
        n = k;
        rd = bus.rsp_rdata;
        err = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vecs++;
    if (bus.mem_trig !== 1'b0) begin
      errs++;
      $display("FAIL rst_trig: got %b want 0", bus.mem_trig);
    end
    vecs++;
    if (bus.req_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_ready: got %b want 0", bus.req_ready);
    end
    vecs++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 10'h000) begin
      errs++;
      $display("FAIL rst_rsp: got %b/%b/%h want 0/0/00",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    vecs++;
    if ({bus.mem_rw, bus.mem_adbus} !== 9'h000) begin
      errs++;
      $display("FAIL rst_bus: got %b/%h want 0/00",
               bus.mem_rw, bus.mem_adbus);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    vecs++;
    if (bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_release_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_write;
    int w0;
    int n;
    logic [7:0] rd;
    logic err;
    w0 = writes;
    start_req(1'b0, 8'h3C, 8'hA5);
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    vecs++;
    if (bus.mem_adbus !== 8'h3C || bus.mem_rw !== 1'b0) begin
      errs++;
      $display("FAIL wr_addr_phase: got %h/%b want 3c/0",
               bus.mem_adbus, bus.mem_rw);
    end
    @(posedge CLK);
    #1;
    vecs++;
    if (bus.mem_adbus !== 8'hA5 || bus.rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL wr_data_phase: got %h/%b want a5/0",
               bus.mem_adbus, bus.rsp_valid);
    end
    @(posedge CLK);
    #1;
    vecs++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin
      errs++;
      $display("FAIL wr_rsp: got %b/%b want 1/0",
               bus.rsp_valid, bus.rsp_err);
    end
    vecs++;
    if (bus.mem_adbus !== 8'h00) begin
      errs++;
      $display("FAIL wr_resp_adbus: got %h want 00", bus.mem_adbus);
    end
    vecs++;
    if (writes - w0 !== 1) begin
      errs++;
      $display("FAIL wr_count: got %0d want 1", writes - w0);
    end
    do_req(1'b1, 8'h3C, 8'h00, n, rd, err);
    vecs++;
    if (n !== 3 || rd !== 8'hA5) begin
      errs++;
      $display("FAIL wr_readback: got n=%0d %h want n=3 a5", n, rd);
    end
  endtask

  task automatic test_read;
    int n;
    logic [7:0] rd;
    logic err;
    do_req(1'b0, 8'h10, 8'h77, n, rd, err);
    start_req(1'b1, 8'h10, 8'h00);
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    vecs++;
    if (bus.mem_rw !== 1'b1 || bus.mem_adbus !== 8'h10) begin
      errs++;
      $display("FAIL rd_addr_phase: got %b/%h want 1/10",
               bus.mem_rw, bus.mem_adbus);
    end
    n = -1;
    for (int k = 2; k <= 20; k++) begin
      @(posedge CLK);
      #1;
      if (bus.rsp_valid) begin
        n = k;
        break;
      end
    end
    vecs++;
    if (n !== 3) begin
      errs++;
      $display("FAIL rd_latency: got %0d want 3", n);
    end
    vecs++;
    if (bus.rsp_rdata !== 8'h77) begin
      errs++;
      $display("FAIL rd_data: got %h want 77", bus.rsp_rdata);
    end
    vecs++;
    if (bus.mem_trig !== 1'b0) begin
      errs++;
      $display("FAIL rd_resp_trig: got %b want 0", bus.mem_trig);
    end
  endtask

  task automatic test_busy;
    int w0;
    int n;
    logic stall_ok;
    logic [7:0] rd;
    logic err;
    w0 = writes;
    n = -1;
    stall_ok = 1'b1;
    start_req(1'b0, 8'h44, 8'h9C);
    for (int k = 1; k <= 30; k++) begin
      @(posedge CLK);
      #1;
      bus.req_valid = 1'b0;
      if (k >= 2 && k <= 5)
        if (!bus.mem_trig || bus.mem_adbus !== 8'h44)
          stall_ok = 1'b0;
      if (k == 1) force_busy = 1'b1;
      if (k == 5) force_busy = 1'b0;
      if (bus.rsp_valid) begin
        n = k;
        break;
      end
    end
    force_busy = 1'b0;
    vecs++;
    if (stall_ok !== 1'b1) begin
      errs++;
      $display("FAIL busy_hold: got %b want 1", stall_ok);
    end
    vecs++;
    if (n !== 7) begin
      errs++;
      $display("FAIL busy_latency: got %0d want 7", n);
    end
    vecs++;
    if (writes - w0 !== 1) begin
      errs++;
      $display("FAIL busy_writes: got %0d want 1", writes - w0);
    end
    do_req(1'b1, 8'h44, 8'h00, n, rd, err);
    vecs++;
    if (rd !== 8'h9C) begin
      errs++;
      $display("FAIL busy_readback: got %h want 9c", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] g_rdy;
    logic [7:0] g_rsp;
    logic [7:0] g_trig;
    logic [7:0] rd;
    int w0;
    w0 = writes;
    rd = 8'h00;
    start_req(1'b0, 8'h20, 8'h55);
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK);
      #1;
      g_rdy[k]  = bus.req_ready;
      g_rsp[k]  = bus.rsp_valid;
      g_trig[k] = bus.mem_trig;
      if (k == 6) rd = bus.rsp_rdata;
      if (k == 0) begin
        bus.req_rw    = 1'b1;
        bus.req_addr  = 8'h20;
        bus.req_wdata = 8'h00;
      end
      if (k == 4) bus.req_valid = 1'b0;
    end
    vecs++;
    if (g_rdy !== 8'b1000_1000) begin
      errs++;
      $display("FAIL b2b_ready: got %b want 10001000", g_rdy);
    end
    vecs++;
    if (g_rsp !== 8'b0100_0100) begin
      errs++;
      $display("FAIL b2b_rsp: got %b want 01000100", g_rsp);
    end
    vecs++;
    if (g_trig !== 8'b0011_0011) begin
      errs++;
      $display("FAIL b2b_trig: got %b want 00110011", g_trig);
    end
    vecs++;
    if (rd !== 8'h55 || writes - w0 !== 1) begin
      errs++;
      $display("FAIL b2b_data: got %h/%0d want 55/1", rd, writes - w0);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    logic rdy_ok;
    start_req(1'b1, 8'h10, 8'h00);
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    @(posedge CLK);
    #1;
    vecs++;
    if (bus.mem_trig !== 1'b1 || bus.req_ready !== 1'b0) begin
      errs++;
      $display("FAIL mid_pre: got %b/%b want 1/0",
               bus.mem_trig, bus.req_ready);
    end
    RST = 1'b0;
    #1;
    vecs++;
    if ({bus.mem_trig, bus.rsp_valid, bus.req_ready} !== 3'b000) begin
      errs++;
      $display("FAIL mid_async: got %b%b%b want 000",
               bus.mem_trig, bus.rsp_valid, bus.req_ready);
    end
    @(negedge CLK);
    RST = 1'b1;
    seen = 1'b0;
    rdy_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
      if (!bus.req_ready) rdy_ok = 1'b0;
    end
    vecs++;
    if (seen !== 1'b0 || rdy_ok !== 1'b1) begin
      errs++;
      $display("FAIL mid_after: got rsp=%b rdy=%b want 0/1",
               seen, rdy_ok);
    end
  endtask

`ifdef MEM_REQ_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    logic [7:0] rd;
    logic err;
    hang = 1'b1;
    do_req(1'b1, 8'h10, 8'h00, n, rd, err);
    hang = 1'b0;
    vecs++;
    if (n !== 17 || err !== 1'b1 || rd !== 8'h00) begin
      errs++;
      $display("FAIL tmo_abort: got n=%0d err=%b %h want 17/1/00",
               n, err, rd);
    end
    do_req(1'b1, 8'h10, 8'h00, n, rd, err);
    vecs++;
    if (n !== 3 || err !== 1'b0 || rd !== 8'h77) begin
      errs++;
      $display("FAIL tmo_recover: got n=%0d err=%b %h want 3/0/77",
               n, err, rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_REQ_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
- Initiator-side bus master for the 8-bit single-port memory bus (trigger / rW / multiplexed adbus / busy).
- Sits between the CPU core's load/store/fetch path and the memory responder.
- Accepts one core request at a time and sequences the address phase and the write-data phase on the shared adbus.
- Captures read data and returns a single-cycle response to the core.

Parameters:
- ADDR_W, 8, address width; equals adbus width.
- DATA_W, 8, data width; must equal ADDR_W because adbus is multiplexed.
- TIMEOUT_CYCLES, 16, wait-cycle limit before abort (used only when MEM_REQ_TIMEOUT_EN is defined).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  requester can accept; high only in IDLE.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads.
- rsp_err  out  1  timeout abort flag; valid with rsp_valid.
- mem_trig  out  1  bus request (responder's "triggered").
- mem_rw  out  1  bus direction, 1 = read.
- mem_adbus  out  ADDR_W  address in the address phase, write data in the data phase.
- mem_busy  in  1  responder running flag (its "isRunning").
- mem_rdata  in  DATA_W  responder read data; valid while mem_busy=1 on a read.

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs registered low; req_ready=1 after reset release.
- Reset mid-transaction aborts immediately, with no response. mem_trig drops asynchronously so the responder never sees a stale request.
- States: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready at an edge: latch rw, addr and wdata; set mem_trig=1, mem_rw=rw, mem_adbus=addr; go to ADDR.
- ADDR (address phase): hold mem_trig, mem_rw and mem_adbus.
  - Edge with mem_busy=0: the responder accepts at this edge; go to WAIT.
    - Write: mem_adbus <= wdata at this same edge, so data is on the bus in the responder's write cycle.
    - Read: mem_adbus is held.
  - Edge with mem_busy=1: the responder is still finishing a previous operation; stay in ADDR and hold.
- WAIT:
  - Edge with mem_busy=1: mem_trig <= 0.
    - Read: rsp_rdata <= mem_rdata.
    - Write: rsp_rdata <= 0.
    - Go to RESP.
  - mem_adbus keeps wdata until that edge on writes.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_err as determined; mem_adbus <= 0.
  - Go to IDLE. A new request can be accepted at the next edge (one idle cycle minimum between requests).
- Nominal latency, with the responder idle at the request edge E0:
  - ADDR during E0–E1.
  - WAIT during E1–E2.
  - rsp_valid high in the cycle after E2, i.e. 3 cycles after the request handshake.
- req_valid while not in IDLE is ignored; req_ready=0 in ADDR, WAIT and RESP.
- rsp_rdata holds its value between responses.
- mem_trig is never high in IDLE or RESP. This guarantees the responder cannot double-accept.

Optional Feature:
- Macro: MEM_REQ_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ADDR and increments every cycle in ADDR and WAIT.
  - When it reaches TIMEOUT_CYCLES: mem_trig <= 0, rsp_rdata <= 0, rsp_err <= 1, go to RESP.
  - Normal completion at the same edge as the timeout has priority (rsp_err=0).
- Not defined:
  - No counter; the requester waits indefinitely in ADDR and WAIT.
  - rsp_err is tied to 0.

Test Plan:
- Write: addr=8'h3C, wdata=8'hA5, responder idle -> mem_adbus=8'h3C for 1 cycle, then 8'hA5 for 1 cycle; rsp_valid 3 cycles after handshake; rsp_err=0; a subsequent read of 8'h3C returns 8'hA5.
- Read: addr=8'h10, memory holds 8'h77 -> mem_rw=1; rsp_rdata=8'h77 with rsp_valid; mem_trig low in the RESP cycle.
- Responder busy: force mem_busy=1 for 4 cycles at request time -> stays in ADDR with address held; responder accepts after busy drops; rsp_valid at 3+4 cycles; exactly one memory write.
- Back-to-back: req_valid held high with 2 requests -> second is accepted only after RESP returns to IDLE; req_ready=0 throughout the first; no overlapping mem_trig.
- Reset mid-operation: RST=0 while in WAIT -> mem_trig, rsp_valid and req_ready=0 immediately; after release req_ready=1 and no rsp_valid pulse.
- MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_busy held 0 after acceptance -> rsp_valid with rsp_err=1 and rsp_rdata=8'h00 on timeout; the next request completes normally with rsp_err=0.
